tx_frame_scheduler: RTL

- Shares the single UART-style frame transmitter between NUM_REQ requesting clients.
- Round-robin arbitrates pending frame requests and latches the winner's framesize/framebits.
- Pulses tf to launch the frame, tracks TXI through busy and back to idle, then reports done or err to the owner.
- Owns the transmitter's baudrate configuration register.

---
 rtl/tx_frame_scheduler_pkg.sv | 20 ++
 rtl/tx_frame_scheduler_rr_arbiter.sv | 40 ++++
 rtl/tx_frame_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tx_frame_scheduler_pkg.sv
// Shared types and widths for the transmit frame scheduler slice.
package tx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_IDLE
   } tx_sched_state_t;

   localparam int FRAME_BITS = 128;
   localparam int FSIZE_W    = 4;
   localparam int BAUD_W     = 8;

   // A zero divisor would stall the transmitter, so it is promoted to 1.
   function automatic logic [BAUD_W-1:0] clamp_baud(input logic [BAUD_W-1:0] cfg);
      return (cfg == '0) ? BAUD_W'(1) : cfg;
   endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after the pointer, wrapping.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] pointer,
   input  logic          enable,
   output logic [N-1:0]  winner,
   output logic [IW-1:0] index,
   output logic          valid
);

   logic [IW:0]   sum;
   logic [IW-1:0] pos;

   // Walk the clients starting just after the pointer and keep the first hit.
   always_comb begin
      winner = '0;
      index  = '0;
      valid  = 1'b0;
      sum    = '0;
      pos    = '0;
      if (enable) begin
         for (int k = 1; k <= N; k++) begin
            sum = {1'b0, pointer} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
               sum = sum - (IW+1)'(N);
            end
            pos = sum[IW-1:0];
            if (!valid && req[pos]) begin
               valid       = 1'b1;
               winner[pos] = 1'b1;
               index       = pos;
            end
         end
      end
   end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Shares one frame transmitter between NUM_REQ clients and owns its baud register.
module tx_frame_scheduler
   import tx_pkg::*;
#(
   parameter int                NUM_REQ      = 4,
   parameter int                BUSY_TIMEOUT = 4,
   parameter logic [BAUD_W-1:0] BAUD_RESET   = 8'd16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [FSIZE_W*NUM_REQ-1:0]    req_framesize,
   input  logic [FRAME_BITS*NUM_REQ-1:0] req_framebits,
   input  logic [BAUD_W-1:0]             baud_cfg,
   input  logic                          baud_we,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic [NUM_REQ-1:0]            err,
   output logic                          busy,
   output logic                          tf,
   output logic [FSIZE_W-1:0]            framesize,
   output logic [FRAME_BITS-1:0]         framebits,
   output logic [BAUD_W-1:0]             baudrate,
   input  logic                          TXI
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);

   tx_sched_state_t        state, state_next;
   logic [IW-1:0]          ptr, ptr_next;
   logic [CW-1:0]          cnt, cnt_next;
   logic [NUM_REQ-1:0]     grant_next, done_next, err_next;
   logic                   tf_next;
   logic [FSIZE_W-1:0]     size_next;
   logic [FRAME_BITS-1:0]  bits_next;
   logic [BAUD_W-1:0]      baud_next;

   logic [NUM_REQ-1:0]     arb_winner;
   logic [IW-1:0]          arb_index;
   logic                   arb_valid;
   logic [FSIZE_W-1:0]     size_arr [NUM_REQ];
   logic [FRAME_BITS-1:0]  bits_arr [NUM_REQ];

   // Arbitration is only offered while idle and the transmitter reports idle,
   // which also blocks relaunch after a reset that interrupted a frame.
   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_arb (
      .req     (req),
      .pointer (ptr),
      .enable  ((state == IDLE) && TXI),
      .winner  (arb_winner),
      .index   (arb_index),
      .valid   (arb_valid)
   );

   assign busy = (state != IDLE);

   // Unpack the flat client buses so the winner's fields can be indexed directly.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         size_arr[i] = req_framesize[i*FSIZE_W +: FSIZE_W];
         bits_arr[i] = req_framebits[i*FRAME_BITS +: FRAME_BITS];
      end
   end

   // Next-state and registered-output values; done/err/tf default to no pulse.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      cnt_next   = cnt;
      grant_next = grant;
      done_next  = '0;
      err_next   = '0;
      tf_next    = 1'b0;
      size_next  = framesize;
      bits_next  = framebits;
      baud_next  = baudrate;
      case (state)
         IDLE: begin
            if (arb_valid) begin
               grant_next = arb_winner;
               size_next  = size_arr[arb_index];
               bits_next  = bits_arr[arb_index];
               ptr_next   = arb_index;
               tf_next    = (size_arr[arb_index] != '0);
               state_next = LAUNCH;
            end else if (baud_we) begin
               baud_next = clamp_baud(baud_cfg);
            end
         end
         LAUNCH: begin
            if (framesize == '0) begin
               err_next   = grant;
               grant_next = '0;
               state_next = IDLE;
            end else begin
               cnt_next   = '0;
               state_next = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!TXI) begin
               state_next = WAIT_IDLE;
            end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
               err_next   = grant;
               grant_next = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         WAIT_IDLE: begin
            if (TXI) begin
               done_next  = grant;
               grant_next = '0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, pointer and all transmitter-facing registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= IW'(NUM_REQ - 1);
         cnt       <= '0;
         grant     <= '0;
         done      <= '0;
         err       <= '0;
         tf        <= 1'b0;
         framesize <= '0;
         framebits <= '0;
         baudrate  <= BAUD_RESET;
      end else begin
         state     <= state_next;
         ptr       <= ptr_next;
         cnt       <= cnt_next;
         grant     <= grant_next;
         done      <= done_next;
         err       <= err_next;
         tf        <= tf_next;
         framesize <= size_next;
         framebits <= bits_next;
         baudrate  <= baud_next;
      end
   end

endmodule
